// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int LSU_W = 32;

   // Memory command encodings from the decode stage
   localparam logic [1:0] MEN_X  = 2'd0;
   localparam logic [1:0] MEN_LD = 2'd1;
   localparam logic [1:0] MEN_ST = 2'd2;

   // funct3 size/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

   // Access size from funct3; every unlisted code (011, 11x) falls to word
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   // True when the byte offset does not fit the natural alignment of the size
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3_size(f3))
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface lsu_dmem_if;
   import lsu_pkg::*;

   logic             req;
   logic             we;
   logic [LSU_W-1:0] addr;
   logic [3:0]       be;
   logic [LSU_W-1:0] wdata;
   logic             gnt;
   logic             rvalid;
   logic [LSU_W-1:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]       i_funct3,
   input  logic [1:0]       i_off,
   input  logic [LSU_W-1:0] i_wdata,
   input  logic [LSU_W-1:0] i_rdata,
   output logic [3:0]       o_be,
   output logic [LSU_W-1:0] o_wdata,
   output logic [LSU_W-1:0] o_rdata
);

   size_e       w_size;
   logic        w_signed;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_size   = f3_size(i_funct3);
   assign w_signed = ~i_funct3[2];
   assign w_byte   = i_rdata[8*i_off +: 8];
   assign w_half   = i_rdata[16*i_off[1] +: 16];

   // Select enables, replicated store lanes and extended load value by size
   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (w_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
         end
         SZ_H: begin
            o_be    = 4'b0011 << i_off;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = w_signed ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
         end
         default: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: EX memory command -> data-memory transaction -> extended load data.
// Only XLEN=32 is supported.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN = LSU_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_ex_valid,
   input  logic [1:0]      i_mem_cmd,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_stall,
   output logic            o_misalign,
   output logic [XLEN-1:0] o_load_data,
   output logic            o_load_valid,
   lsu_dmem_if.master      dmem
);

   lsu_state_e      r_state;
   lsu_state_e      w_next;

   logic            r_we;
   logic [XLEN-1:0] r_addr;
   logic [1:0]      r_off;
   logic [2:0]      r_funct3;
   logic [3:0]      r_be;
   logic [XLEN-1:0] r_wdata;
   logic [XLEN-1:0] r_load_data;
   logic            r_load_valid;
   logic            r_misalign;

   logic            w_access;
   logic            w_mis;
   logic            w_latch;
   logic            w_capture;
   logic            w_req;
   logic            w_stall;
   logic [2:0]      w_al_funct3;
   logic [1:0]      w_al_off;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;
   logic [XLEN-1:0] w_rdata_ext;

   assign w_access = i_ex_valid && (i_mem_cmd != MEN_X);
   assign w_mis    = is_misaligned(i_funct3, i_addr[1:0]);

   // The aligner sees the live EX fields while idle and the latched ones afterwards
   assign w_al_funct3 = (r_state == S_IDLE) ? i_funct3    : r_funct3;
   assign w_al_off    = (r_state == S_IDLE) ? i_addr[1:0] : r_off;

   lsu_align u_align (
      .i_funct3 (w_al_funct3),
      .i_off    (w_al_off),
      .i_wdata  (i_wdata),
      .i_rdata  (dmem.rdata),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata_ext)
   );

   // Next-state and handshake decode; stall is combinational so the first
   // cycle of an access already freezes the pipeline
   always_comb begin
      w_next    = r_state;
      w_stall   = 1'b0;
      w_latch   = 1'b0;
      w_capture = 1'b0;
      w_req     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access && !w_mis) begin
               w_latch = 1'b1;
               w_stall = 1'b1;
               w_next  = S_REQ;
            end
         end
         S_REQ: begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            if (dmem.gnt) begin
               w_next = r_we ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            w_stall = 1'b1;
            if (dmem.rvalid) begin
               w_capture = 1'b1;
               w_next    = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // One-cycle status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign   <= 1'b0;
         r_load_valid <= 1'b0;
      end else begin
         r_misalign   <= (r_state == S_IDLE) && w_access && w_mis;
         r_load_valid <= w_capture;
      end
   end

   // Request fields latched once on entry so they stay stable until granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_off    <= 2'b00;
         r_funct3 <= 3'b000;
         r_be     <= 4'b0000;
         r_wdata  <= '0;
      end else if (w_latch) begin
         r_we     <= (i_mem_cmd == MEN_ST);
         r_addr   <= {i_addr[XLEN-1:2], 2'b00};
         r_off    <= i_addr[1:0];
         r_funct3 <= i_funct3;
         r_be     <= w_be;
         r_wdata  <= w_wdata;
      end
   end

   // Load result register, written only when the response arrives in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_data <= '0;
      end else if (w_capture) begin
         r_load_data <= w_rdata_ext;
      end
   end

   assign o_stall      = w_stall;
   assign o_misalign   = r_misalign;
   assign o_load_data  = r_load_data;
   assign o_load_valid = r_load_valid;

   assign dmem.req   = w_req;
   assign dmem.we    = w_req & r_we;
   assign dmem.addr  = r_addr;
   assign dmem.be    = r_be;
   assign dmem.wdata = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the load/store unit.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [1:0]  mem_cmd;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        misalign;
   logic [31:0] load_data;
   logic        load_valid;

   lsu_dmem_if dmem_if ();

   lsu #(.XLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_ex_valid   (ex_valid),
      .i_mem_cmd    (mem_cmd),
      .i_funct3     (funct3),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_stall      (stall),
      .o_misalign   (misalign),
      .o_load_data  (load_data),
      .o_load_valid (load_valid),
      .dmem         (dmem_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_load;

   typedef struct {
      logic [1:0]  cmd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gd;
      int          rd;
      logic [3:0]  be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      logic        mis;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   // Reference behaviour from the byte-lane rules: an n-byte access at byte
   // offset off touches lanes off..off+n-1; store lanes repeat the low n bytes;
   // load value is the n bytes at off, sign- or zero-extended.
   function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 output logic mis, output logic [3:0] be,
                                 output logic [31:0] ewd, output logic [31:0] eld);
      int n;
      int off;
      logic [31:0] sh;
      logic [63:0] m;
      off = int'(a[1:0]);
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis = (off % n) != 0;
      be = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + n) be[i] = 1'b1;
         ewd[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      sh = rd >> (8 * off);
      m = (64'd1 << (8 * n)) - 64'd1;
      eld = sh & m[31:0];
      if (!f3[2] && sh[8*n-1]) eld = eld | ~m[31:0];
   endfunction

   // Drive one EX access and walk it through the handshake, checking every cycle
   task automatic run_access(input string nm, input logic [1:0] cmd, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int gd, input int rvd, input logic [3:0] ebe,
                             input logic [31:0] ewd, input logic [31:0] eld, input logic mis);
      int scnt;
      logic [31:0] eaddr;
      eaddr = {a[31:2], 2'b00};
      scnt = 0;
      ex_valid = 1'b1;
      mem_cmd  = cmd;
      funct3   = f3;
      addr     = a;
      wdata    = wd;
      #1;
      if (mis) begin
         chk1({nm, " mis stall"}, stall, 1'b0);
         @(negedge clk);
         ex_valid = 1'b0;
         chk1({nm, " misalign"}, misalign, 1'b1);
         chk1({nm, " mis req"}, dmem_if.req, 1'b0);
         chk({nm, " mis load_data"}, load_data, last_load);
         @(negedge clk);
         chk1({nm, " misalign pulse"}, misalign, 1'b0);
         chk1({nm, " mis req2"}, dmem_if.req, 1'b0);
         return;
      end
      chk1({nm, " idle stall"}, stall, 1'b1);
      chk1({nm, " idle req"}, dmem_if.req, 1'b0);
      if (stall) scnt++;
      @(negedge clk);
      for (int i = 0; i <= gd; i++) begin
         chk1({nm, " req"}, dmem_if.req, 1'b1);
         chk1({nm, " we"}, dmem_if.we, cmd == MEN_ST);
         chk({nm, " addr"}, dmem_if.addr, eaddr);
         chk({nm, " be"}, 32'(dmem_if.be), 32'(ebe));
         if (cmd == MEN_ST) chk({nm, " wdata"}, dmem_if.wdata, ewd);
         if (stall) scnt++;
         dmem_if.rvalid = (i < gd);
         dmem_if.rdata  = $urandom;
         dmem_if.gnt    = (i == gd);
         @(negedge clk);
         dmem_if.gnt    = 1'b0;
         dmem_if.rvalid = 1'b0;
      end
      if (cmd == MEN_LD) begin
         for (int i = 0; i <= rvd; i++) begin
            chk1({nm, " wait req"}, dmem_if.req, 1'b0);
            chk1({nm, " wait lv"}, load_valid, 1'b0);
            if (stall) scnt++;
            dmem_if.rvalid = (i == rvd);
            dmem_if.rdata  = (i == rvd) ? rd : $urandom;
            @(negedge clk);
            dmem_if.rvalid = 1'b0;
         end
      end
      // DONE
      ex_valid = 1'b0;
      chk1({nm, " done stall"}, stall, 1'b0);
      chk1({nm, " done req"}, dmem_if.req, 1'b0);
      if (cmd == MEN_LD) begin
         chk1({nm, " load_valid"}, load_valid, 1'b1);
         chk({nm, " load_data"}, load_data, eld);
         last_load = eld;
      end else begin
         chk1({nm, " st load_valid"}, load_valid, 1'b0);
         chk({nm, " st load_data"}, load_data, last_load);
      end
      chk({nm, " stall cycles"}, scnt, (cmd == MEN_LD) ? 3 + gd + rvd : 2 + gd);
      dmem_if.rvalid = 1'b1;
      dmem_if.rdata  = $urandom;
      @(negedge clk);
      dmem_if.rvalid = 1'b0;
      chk1({nm, " lv pulse"}, load_valid, 1'b0);
      chk({nm, " hold load_data"}, load_data, last_load);
      chk1({nm, " idle req after"}, dmem_if.req, 1'b0);
   endtask

   initial begin
      logic        m_mis;
      logic [3:0]  m_be;
      logic [31:0] m_wd;
      logic [31:0] m_ld;
      logic [1:0]  r_cmd;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      logic [31:0] r_rd;
      logic [2:0]  ld_codes [8];

      rst_n = 1'b0;
      ex_valid = 1'b0;
      mem_cmd = MEN_X;
      funct3 = 3'b000;
      addr = '0;
      wdata = '0;
      dmem_if.gnt = 1'b0;
      dmem_if.rvalid = 1'b0;
      dmem_if.rdata = '0;
      last_load = '0;

      vecs[0] = '{MEN_ST, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1] = '{MEN_ST, F3_B,  32'h103, 32'h000000A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[2] = '{MEN_LD, F3_B,  32'h201, 32'h0,        32'h12348056, 0, 0, 4'b0010, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[3] = '{MEN_LD, F3_BU, 32'h201, 32'h0,        32'h12348056, 0, 0, 4'b0010, 32'h0,        32'h00000080, 1'b0};
      vecs[4] = '{MEN_LD, F3_HU, 32'h202, 32'h0,        32'hBEEF1234, 3, 2, 4'b1100, 32'h0,        32'h0000BEEF, 1'b0};
      vecs[5] = '{MEN_LD, F3_W,  32'h102, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[6] = '{MEN_ST, F3_H,  32'h102, 32'h1234ABCD, 32'h0,        1, 0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
      vecs[7] = '{MEN_LD, F3_H,  32'h300, 32'h0,        32'h00008001, 0, 1, 4'b0011, 32'h0,        32'hFFFF8001, 1'b0};
      vecs[8] = '{MEN_LD, F3_W,  32'h304, 32'h0,        32'hCAFEF00D, 2, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0};
      vecs[9] = '{MEN_LD, 3'b011,32'h308, 32'h0,        32'h87654321, 0, 0, 4'b1111, 32'h0,        32'h87654321, 1'b0};

      // Reset state
      @(negedge clk);
      #1;
      chk1("rst stall", stall, 1'b0);
      chk1("rst misalign", misalign, 1'b0);
      chk1("rst load_valid", load_valid, 1'b0);
      chk("rst load_data", load_data, 32'h0);
      chk1("rst req", dmem_if.req, 1'b0);
      chk1("rst we", dmem_if.we, 1'b0);
      chk("rst addr", dmem_if.addr, 32'h0);
      chk("rst be", 32'(dmem_if.be), 32'h0);
      chk("rst wdata", dmem_if.wdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 10; i++) begin
         run_access($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].f3, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].gd, vecs[i].rd, vecs[i].be,
                    vecs[i].exp_wd, vecs[i].exp_ld, vecs[i].mis);
      end

      // Non-accesses and stray handshake inputs while idle are ignored
      ex_valid = 1'b0; mem_cmd = MEN_LD; addr = 32'h500;
      dmem_if.gnt = 1'b1; dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h55AA55AA;
      #1;
      chk1("noacc stall", stall, 1'b0);
      @(negedge clk);
      ex_valid = 1'b1; mem_cmd = MEN_X;
      #1;
      chk1("menx stall", stall, 1'b0);
      chk1("noacc req", dmem_if.req, 1'b0);
      chk1("noacc lv", load_valid, 1'b0);
      @(negedge clk);
      ex_valid = 1'b0;
      dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
      chk1("menx req", dmem_if.req, 1'b0);
      chk1("menx lv", load_valid, 1'b0);
      chk("noacc load_data", load_data, last_load);
      @(negedge clk);

      // Randomized against the lane model
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      for (int t = 0; t < 60; t++) begin
         r_cmd = ($urandom_range(0, 1) == 0) ? MEN_LD : MEN_ST;
         r_f3  = (r_cmd == MEN_LD) ? ld_codes[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
         r_addr = $urandom;
         r_wd = $urandom;
         r_rd = $urandom;
         model(r_f3, r_addr, r_wd, r_rd, m_mis, m_be, m_wd, m_ld);
         run_access($sformatf("rnd%0d", t), r_cmd, r_f3, r_addr, r_wd, r_rd,
                    $urandom_range(0, 3), $urandom_range(0, 3), m_be, m_wd, m_ld, m_mis);
      end

      // Reset while a load waits for its response
      ex_valid = 1'b1; mem_cmd = MEN_LD; funct3 = F3_W; addr = 32'h400;
      @(negedge clk);
      dmem_if.gnt = 1'b1;
      @(negedge clk);
      dmem_if.gnt = 1'b0;
      chk1("wait stall", stall, 1'b1);
      rst_n = 1'b0;
      ex_valid = 1'b0;
      #1;
      chk1("midrst req", dmem_if.req, 1'b0);
      chk1("midrst stall", stall, 1'b0);
      chk("midrst load_data", load_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_if.rvalid = 1'b1;
      dmem_if.rdata = 32'h13572468;
      @(negedge clk);
      dmem_if.rvalid = 1'b0;
      chk1("postrst lv", load_valid, 1'b0);
      chk("postrst load_data", load_data, 32'h0);
      chk1("postrst stall", stall, 1'b0);
      chk1("postrst req", dmem_if.req, 1'b0);
      @(negedge clk);
      chk1("postrst lv2", load_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
